// File: rtl/ctrl_pipe_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_if -- bundle between the ID stage / datapath and ctrl_pipe.
//
// Signals:
//   id_valid     ID holds a real instruction            (master -> slave)
//   id_instr     32-bit instruction in ID               (master -> slave)
//   stall        external freeze, e.g. memory wait      (master -> slave)
//   flush        kill the instruction entering stage 0  (master -> slave)
//   id_ctrl      combinational decode of id_instr       (slave -> master)
//   stage_ctrl   registered control words, stage k at
//                [k*CTRL_W +: CTRL_W]                   (slave -> master)
//   hazard_stall load-use hazard, IF/ID must hold       (slave -> master)
//   id_ready     !stall && !hazard_stall                (slave -> master)
//
// master = pipeline front end / datapath, slave = ctrl_pipe.
// ---------------------------------------------------------------------------
interface ctrl_pipe_if #(
  parameter int STAGES = 3
);
  localparam int CTRL_W = 28;

  logic                     id_valid;
  logic [31:0]              id_instr;
  logic                     stall;
  logic                     flush;
  logic [CTRL_W-1:0]        id_ctrl;
  logic [STAGES*CTRL_W-1:0] stage_ctrl;
  logic                     hazard_stall;
  logic                     id_ready;

  modport master (
    output id_valid, id_instr, stall, flush,
    input  id_ctrl, stage_ctrl, hazard_stall, id_ready
  );

  modport slave (
    input  id_valid, id_instr, stall, flush,
    output id_ctrl, stage_ctrl, hazard_stall, id_ready
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe -- pipelined MIPS control unit.
//
// Decodes the instruction in ID into a 28-bit control word and carries it
// through STAGES registered stages (0 = EX, 1 = MEM, 2 = WB, ...). Stall,
// flush and the load-use bubble are handled here so the datapath only
// consumes the per-stage taps.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   bus           ctrl_pipe_if.slave (id_valid, id_instr, stall, flush in;
//                 id_ctrl, stage_ctrl, hazard_stall, id_ready out)
//   illegal_seen  sticky illegal-instruction flag (only with
//                 CTRL_ILLEGAL_TRAP_EN defined)
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : unknown opcode / R-type funct decodes to a word carrying only
//               valid and illegal; illegal_seen sets when such a word enters
//               the last stage and holds until reset.
//   undefined : unknown encodings decode as a plain R-type, illegal bit is 0.
//
// Control word: [27] valid [26:22] dst [21] RegWrite [20] MemRead
//   [19] MemWrite [18] ALUSrcA [17] ALUSrcB [16] ExtOp [15] LuiOp
//   [14:13] Jump [12:11] MemtoReg [10:9] RegDst [8:7] PCSource
//   [6:4] ALUOp [3:1] Branch [0] illegal. All-zero word = bubble.
// STAGES legal range is 1..4.
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  ctrl_pipe_if.slave  bus
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_seen
`endif
);
  localparam int CTRL_W = 28;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;
  logic       unusedShamt;

  assign opcode      = bus.id_instr[31:26];
  assign rs          = bus.id_instr[25:21];
  assign rt          = bus.id_instr[20:16];
  assign rd          = bus.id_instr[15:11];
  assign funct       = bus.id_instr[5:0];
  assign unusedShamt = ^bus.id_instr[10:6];

  // Decoded fields
  logic       regWrite, memRead, memWrite, aluSrcA, aluSrcB, extOp, luiOp;
  logic       illegal, readsRt;
  logic [1:0] jump, memtoReg, regDst, pcSource;
  logic [2:0] aluOp, branch;
  logic [4:0] dst;
  logic [CTRL_W-1:0] idCtrl;

  always_comb begin
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    aluSrcA  = 1'b0;
    aluSrcB  = 1'b0;
    extOp    = 1'b1;
    luiOp    = 1'b0;
    illegal  = 1'b0;
    jump     = 2'b00;
    memtoReg = 2'b00;
    regDst   = 2'b00;
    pcSource = 2'b00;
    aluOp    = 3'b000;
    branch   = 3'b000;
    dst      = 5'd0;
    idCtrl   = '0;

    case (opcode)
      6'h23: begin regWrite = 1'b1; memRead = 1'b1; memtoReg = 2'b01; aluSrcB = 1'b1; end
      6'h2b: begin memWrite = 1'b1; aluSrcB = 1'b1; end
      6'h0f: begin regWrite = 1'b1; luiOp = 1'b1; memtoReg = 2'b11; aluSrcB = 1'b1; end
      6'h08, 6'h09: begin regWrite = 1'b1; aluSrcB = 1'b1; end
      6'h0c: begin regWrite = 1'b1; aluSrcB = 1'b1; aluOp = 3'b011; extOp = 1'b0; end
      6'h0a, 6'h0b: begin regWrite = 1'b1; aluSrcB = 1'b1; aluOp = 3'b100; end
      6'h04: begin aluOp = 3'b001; branch = 3'b001; end
      6'h05: begin aluOp = 3'b001; branch = 3'b010; end
      6'h06: begin aluOp = 3'b001; branch = 3'b011; end
      6'h07: begin aluOp = 3'b001; branch = 3'b100; end
      6'h01: begin aluOp = 3'b001; branch = 3'b101; end
      6'h02: begin jump = 2'b01; pcSource = 2'b01; end
      6'h03: begin
        jump = 2'b01; pcSource = 2'b01;
        regWrite = 1'b1; regDst = 2'b10; memtoReg = 2'b10;
      end
      6'h00: begin
        regWrite = 1'b1; regDst = 2'b01; aluOp = 3'b010;
        case (funct)
          6'h00, 6'h02, 6'h03: aluSrcA = 1'b1;
          6'h08: begin regWrite = 1'b0; jump = 2'b10; pcSource = 2'b10; end
          6'h09: begin jump = 2'b10; pcSource = 2'b10; regDst = 2'b10; memtoReg = 2'b10; end
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: ;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal = 1'b1;
`endif
          end
        endcase
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        regWrite = 1'b1; regDst = 2'b01; aluOp = 3'b010;
`endif
      end
    endcase

    case (regDst)
      2'b00:   dst = rt;
      2'b01:   dst = rd;
      2'b10:   dst = 5'd31;
      default: dst = 5'd0;
    endcase
    if (!regWrite) dst = 5'd0;

    idCtrl = {1'b1, dst, regWrite, memRead, memWrite, aluSrcA, aluSrcB, extOp,
              luiOp, jump, memtoReg, regDst, pcSource, aluOp, branch, illegal};
    // An illegal word keeps only valid and the illegal flag.
    if (illegal) idCtrl = {1'b1, 26'd0, 1'b1};
    if (!bus.id_valid) idCtrl = '0;
  end

  // rt is a source only for R-type, sw, beq and bne.
  assign readsRt = (opcode == 6'h00) || (opcode == 6'h2b) ||
                   (opcode == 6'h04) || (opcode == 6'h05);

  // Pipeline state
  logic [CTRL_W-1:0] stageReg  [STAGES];
  logic [CTRL_W-1:0] stageNext [STAGES];
  logic [STAGES*CTRL_W-1:0] stagePacked;
  logic [4:0] s0Dst;
  logic       hazard;

  assign s0Dst  = stageReg[0][26:22];
  assign hazard = stageReg[0][27] && stageReg[0][20] && (s0Dst != 5'd0) &&
                  ((s0Dst == rs) || ((s0Dst == rt) && readsRt));

  // Stage 0: a stall holds it unless flush kills it; otherwise a flush,
  // hazard or empty ID inserts a bubble.
  always_comb begin
    stageNext[0] = stageReg[0];
    if (bus.stall) begin
      if (bus.flush) stageNext[0] = '0;
    end else if (bus.flush || hazard || !bus.id_valid) begin
      stageNext[0] = '0;
    end else begin
      stageNext[0] = idCtrl;
    end
  end

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
      assign stageNext[gi] = bus.stall ? stageReg[gi] : stageReg[gi-1];
    end
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_pack
      assign stagePacked[gi*CTRL_W +: CTRL_W] = stageReg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) stageReg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stageReg[k] <= stageNext[k];
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sets on the same edge the illegal word lands in the last stage.
  logic illegalSeenReg;
  always_ff @(posedge clk) begin
    if (reset) illegalSeenReg <= 1'b0;
    else if (stageNext[STAGES-1][0]) illegalSeenReg <= 1'b1;
  end
  assign illegal_seen = illegalSeenReg;
`endif

  assign bus.id_ctrl      = idCtrl;
  assign bus.stage_ctrl   = stagePacked;
  assign bus.hazard_stall = hazard;
  assign bus.id_ready     = !bus.stall && !hazard;
endmodule
